// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional statistics counters are compiled in with `define BTB_STATS_EN.
module branch_target_buffer #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_pc_next,
    input  logic [ADDR_WIDTH-1:0] i_pc_current,
    input  logic                  i_upd_valid,
    input  logic [ADDR_WIDTH-1:0] i_upd_pc,
    input  logic                  i_upd_taken,
    input  logic [ADDR_WIDTH-1:0] i_upd_target,
`ifdef BTB_STATS_EN
    output logic [31:0]           o_stat_lookups,
    output logic [31:0]           o_stat_hits,
    output logic [31:0]           o_stat_updates,
    output logic [31:0]           o_stat_dir_wrong,
`endif
    output logic                  o_is_branch,
    output logic                  o_prediction,
    output logic [ADDR_WIDTH-1:0] o_target
);
    localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]    r_valid;
    logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
    logic [1:0]            r_ctr    [ENTRIES];

    logic                  r_rd_valid;
    logic [TAG_BITS-1:0]   r_rd_tag;
    logic [ADDR_WIDTH-1:0] r_rd_target;
    logic [1:0]            r_rd_ctr;

    logic [INDEX_BITS-1:0] w_rd_idx;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]   w_upd_tag;
    logic [TAG_BITS-1:0]   w_cur_tag;
    logic                  w_upd_hit;
    logic                  w_wr;
    logic [TAG_BITS-1:0]   w_new_tag;
    logic [ADDR_WIDTH-1:0] w_new_target;
    logic [1:0]            w_new_ctr;
    logic                  w_unused;

    assign w_rd_idx  = i_pc_next[INDEX_BITS+1:2];
    assign w_upd_idx = i_upd_pc[INDEX_BITS+1:2];
    assign w_upd_tag = i_upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_cur_tag = i_pc_current[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    assign w_unused = ^{i_pc_next[ADDR_WIDTH-1:INDEX_BITS+2], i_pc_next[1:0],
                        i_pc_current[INDEX_BITS+1:0], i_upd_pc[1:0], r_rd_ctr[0]};

    // Post-update entry contents; an update coinciding with reset is dropped.
    always_comb begin
        w_wr         = 1'b0;
        w_new_tag    = r_tag[w_upd_idx];
        w_new_target = r_target[w_upd_idx];
        w_new_ctr    = r_ctr[w_upd_idx];
        if (i_upd_valid && !rst) begin
            if (w_upd_hit) begin
                w_wr = 1'b1;
                if (i_upd_taken) begin
                    w_new_ctr    = (r_ctr[w_upd_idx] == 2'b11) ? 2'b11 : r_ctr[w_upd_idx] + 2'd1;
                    w_new_target = i_upd_target;
                end else begin
                    w_new_ctr    = (r_ctr[w_upd_idx] == 2'b00) ? 2'b00 : r_ctr[w_upd_idx] - 2'd1;
                end
            end else if (i_upd_taken) begin
                w_wr         = 1'b1;
                w_new_tag    = w_upd_tag;
                w_new_target = i_upd_target;
                w_new_ctr    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_wr) begin
            r_valid[w_upd_idx] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_tag[w_upd_idx]    <= w_new_tag;
            r_target[w_upd_idx] <= w_new_target;
            r_ctr[w_upd_idx]    <= w_new_ctr;
        end
    end

    // Synchronous read with write-first bypass on an index collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid  <= 1'b0;
            r_rd_tag    <= '0;
            r_rd_target <= '0;
            r_rd_ctr    <= '0;
        end else if (w_wr && (w_upd_idx == w_rd_idx)) begin
            r_rd_valid  <= 1'b1;
            r_rd_tag    <= w_new_tag;
            r_rd_target <= w_new_target;
            r_rd_ctr    <= w_new_ctr;
        end else begin
            r_rd_valid  <= r_valid[w_rd_idx];
            r_rd_tag    <= r_tag[w_rd_idx];
            r_rd_target <= r_target[w_rd_idx];
            r_rd_ctr    <= r_ctr[w_rd_idx];
        end
    end

    assign o_is_branch  = r_rd_valid && (r_rd_tag == w_cur_tag);
    assign o_prediction = o_is_branch && r_rd_ctr[1];
    assign o_target     = o_is_branch ? r_rd_target : '0;

`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stat_lookups   <= '0;
            o_stat_hits      <= '0;
            o_stat_updates   <= '0;
            o_stat_dir_wrong <= '0;
        end else begin
            o_stat_lookups <= o_stat_lookups + 32'd1;
            o_stat_hits    <= o_stat_hits + 32'(o_is_branch);
            o_stat_updates <= o_stat_updates + 32'(i_upd_valid);
            if (i_upd_valid && w_upd_hit && (r_ctr[w_upd_idx][1] != i_upd_taken)) begin
                o_stat_dir_wrong <= o_stat_dir_wrong + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.
module tb_branch_target_buffer;
    localparam int unsigned AW = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_next, pc_current, upd_pc, upd_target;
    logic          upd_valid, upd_taken;
    logic          is_branch, prediction;
    logic [AW-1:0] target;
`ifdef BTB_STATS_EN
    logic [31:0]   st_lookups, st_hits, st_updates, st_dir_wrong;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [AW+1:0] got;

    branch_target_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .i_pc_next    (pc_next),
        .i_pc_current (pc_current),
        .i_upd_valid  (upd_valid),
        .i_upd_pc     (upd_pc),
        .i_upd_taken  (upd_taken),
        .i_upd_target (upd_target),
`ifdef BTB_STATS_EN
        .o_stat_lookups   (st_lookups),
        .o_stat_hits      (st_hits),
        .o_stat_updates   (st_updates),
        .o_stat_dir_wrong (st_dir_wrong),
`endif
        .o_is_branch  (is_branch),
        .o_prediction (prediction),
        .o_target     (target)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present pc as both next and current, then let the entry be registered.
    task automatic lookup(input logic [AW-1:0] pc);
        pc_next    = pc;
        pc_current = pc;
        tick();
        #1;
        got = {is_branch, prediction, target};
    endtask

    task automatic update(input logic [AW-1:0] pc, input logic taken, input logic [AW-1:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        tick();
        upd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        pc_next = 26'h40; pc_current = 26'h40;
        tick();
        tick();
        #1;
        n_vec++;
        if ({is_branch, prediction, target} !== {1'b0, 1'b0, 26'h0}) begin
            n_err++;
            $display("FAIL reset_hold got=%h exp=%h", {is_branch, prediction, target}, {2'b00, 26'h0});
        end
        rst = 1'b0;
        lookup(26'h40);
        n_vec++;
        if (got !== {2'b00, 26'h0}) begin
            n_err++;
            $display("FAIL reset_lookup_0x40 got=%h exp=%h", got, {2'b00, 26'h0});
        end
    endtask

    task automatic test_alloc();
        update(26'h100, 1'b1, 26'h200);
        lookup(26'h100);
        n_vec++;
        if (got !== {2'b11, 26'h200}) begin
            n_err++;
            $display("FAIL alloc got=%h exp=%h", got, {2'b11, 26'h200});
        end
    endtask

    task automatic test_counter();
        logic [1:0] exp_pred [7];
        logic       dir [7];
        // Starting at 10: NT,NT -> 01,00; T,T,T -> 01,10,11; T -> 11; NT -> 10
        dir      = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_pred = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
        for (int i = 0; i < 7; i++) begin
            update(26'h100, dir[i], 26'h200);
            lookup(26'h100);
            n_vec++;
            if (got !== {exp_pred[i], 26'h200}) begin
                n_err++;
                $display("FAIL counter_step%0d got=%h exp=%h", i, got, {exp_pred[i], 26'h200});
            end
        end
    endtask

    task automatic test_alias();
        lookup(26'h2000100);
        n_vec++;
        if (got !== {2'b00, 26'h0}) begin
            n_err++;
            $display("FAIL alias_thread_miss got=%h exp=%h", got, {2'b00, 26'h0});
        end
        update(26'h2000100, 1'b1, 26'h2000300);
        lookup(26'h2000100);
        n_vec++;
        if (got !== {2'b11, 26'h2000300}) begin
            n_err++;
            $display("FAIL alias_alloc got=%h exp=%h", got, {2'b11, 26'h2000300});
        end
        lookup(26'h100);
        n_vec++;
        if (got !== {2'b00, 26'h0}) begin
            n_err++;
            $display("FAIL alias_replaced got=%h exp=%h", got, {2'b00, 26'h0});
        end
    endtask

    task automatic test_bypass();
        pc_next = 26'h180; pc_current = 26'h180;
        update(26'h180, 1'b1, 26'h400);
        #1;
        n_vec++;
        if ({is_branch, prediction, target} !== {2'b11, 26'h400}) begin
            n_err++;
            $display("FAIL bypass got=%h exp=%h", {is_branch, prediction, target}, {2'b11, 26'h400});
        end
    endtask

    task automatic test_independent();
        // Allocate at index 0x10 while reading the hit at index 0
        pc_next = 26'h2000100; pc_current = 26'h2000100;
        update(26'h40, 1'b1, 26'h123);
        #1;
        n_vec++;
        if ({is_branch, prediction, target} !== {2'b11, 26'h2000300}) begin
            n_err++;
            $display("FAIL indep_read got=%h exp=%h", {is_branch, prediction, target}, {2'b11, 26'h2000300});
        end
        lookup(26'h40);
        n_vec++;
        if (got !== {2'b11, 26'h123}) begin
            n_err++;
            $display("FAIL indep_write got=%h exp=%h", got, {2'b11, 26'h123});
        end
        // Not-taken miss must not allocate
        update(26'h1C4, 1'b0, 26'h777);
        lookup(26'h1C4);
        n_vec++;
        if (got !== {2'b00, 26'h0}) begin
            n_err++;
            $display("FAIL nt_miss_noalloc got=%h exp=%h", got, {2'b00, 26'h0});
        end
    endtask

    task automatic test_reset_midop();
        rst = 1'b1;
        pc_next = 26'h1C0; pc_current = 26'h1C0;
        update(26'h1C0, 1'b1, 26'h555);
        #1;
        n_vec++;
        if ({is_branch, prediction, target} !== {2'b00, 26'h0}) begin
            n_err++;
            $display("FAIL midop_during_rst got=%h exp=%h", {is_branch, prediction, target}, {2'b00, 26'h0});
        end
        rst = 1'b0;
`ifdef BTB_STATS_EN
        n_vec++;
        if ({st_lookups, st_hits, st_updates, st_dir_wrong} !== 128'h0) begin
            n_err++;
            $display("FAIL stats_after_rst got=%h exp=0", {st_lookups, st_hits, st_updates, st_dir_wrong});
        end
`endif
        lookup(26'h1C0);
        n_vec++;
        if (got !== {2'b00, 26'h0}) begin
            n_err++;
            $display("FAIL midop_dropped got=%h exp=%h", got, {2'b00, 26'h0});
        end
        lookup(26'h40);
        n_vec++;
        if (got !== {2'b00, 26'h0}) begin
            n_err++;
            $display("FAIL midop_valid_cleared got=%h exp=%h", got, {2'b00, 26'h0});
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_bypass();
        test_independent();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
